digital_clock_top: RTL and testbench

//   24-hour HH:MM:SS clock for a 6-digit, common-anode, multiplexed 7-segment display.
//   A prescaler derives a 1 Hz tick from clk; BCD counters hold the time.
//   The block scans one digit at a time: segments on uo_out, digit selects on uio_out.
//   Top-level user tile with standard ui/uo/uio pins.

---
 rtl/digital_clock_pkg.sv | 26 ++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/digital_clock_top.sv | 181 ++++++++++++++++++
 tb/tb_digital_clock_top.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digital_clock_pkg.sv
// Shared types and constants for the HH:MM:SS multiplexed 7-segment clock.
// Segment patterns are active-low {dp, g, f, e, d, c, b, a}.
package digital_clock_pkg;

   typedef logic [3:0] bcd_t;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [2:0] DIG_SU = 3'd0;
   localparam logic [2:0] DIG_ST = 3'd1;
   localparam logic [2:0] DIG_MU = 3'd2;
   localparam logic [2:0] DIG_MT = 3'd3;
   localparam logic [2:0] DIG_HU = 3'd4;
   localparam logic [2:0] DIG_HT = 3'd5;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern; dp is always off here.
module bcd_to_7seg
   import digital_clock_pkg::*;
(
   input  bcd_t       bcd_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/digital_clock_top.sv
// 24-hour BCD clock driving a 6-digit multiplexed common-anode display.
// Optional COLON_BLINK_EN lights dp on digits 2 and 4 during the second half of each second.
module digital_clock_top
   import digital_clock_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 50_000_000,
   parameter int unsigned SCAN_DIV = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
   localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);

   logic [4:0] sync1_q, sync2_q, prev_q;
   logic [4:0] rise;
   logic       set_mode, hold, inc_h, inc_m, clr_s, tick;
   logic       sec_wrap, min_wrap, sec_step, min_step, hr_step;

   logic [PRESC_W-1:0] presc_q, presc_d;
   bcd_t sec_u_q, sec_u_d, sec_t_q, sec_t_d;
   bcd_t min_u_q, min_u_d, min_t_q, min_t_d;
   bcd_t hr_u_q, hr_u_d, hr_t_q, hr_t_d;

   logic [SCAN_W-1:0] scan_q, scan_d;
   logic [2:0]        idx_q, idx_d;
   bcd_t              cur_digit;
   logic [7:0]        seg;
   logic              dp_n;
   logic [7:0]        uo_q, uo_d, uio_q, uio_d;

   logic unused_pins;
   assign unused_pins = ^{ena, uio_in, ui_in[7:5]};

   // Button edges are taken on the synchronised copy only.
   assign rise     = sync2_q & ~prev_q;
   assign set_mode = sync2_q[0];
   assign hold     = sync2_q[4];
   assign inc_h    = set_mode & rise[1];
   assign inc_m    = set_mode & rise[2];
   assign clr_s    = set_mode & rise[3];
   assign tick     = !hold && (presc_q == PRESC_MAX);

   assign sec_wrap = (sec_u_q == 4'd9) && (sec_t_q == 4'd5);
   assign min_wrap = (min_u_q == 4'd9) && (min_t_q == 4'd5);
   assign sec_step = !set_mode && tick;
   assign min_step = set_mode ? inc_m : (tick && sec_wrap);
   assign hr_step  = set_mode ? inc_h : (tick && sec_wrap && min_wrap);

   always_comb begin
      presc_d = presc_q;
      if (clr_s) begin
         presc_d = '0;
      end else if (!hold) begin
         presc_d = tick ? '0 : presc_q + PRESC_W'(1);
      end
   end

   always_comb begin
      sec_u_d = sec_u_q;
      sec_t_d = sec_t_q;
      min_u_d = min_u_q;
      min_t_d = min_t_q;
      hr_u_d  = hr_u_q;
      hr_t_d  = hr_t_q;
      if (clr_s) begin
         sec_u_d = 4'd0;
         sec_t_d = 4'd0;
      end else if (sec_step) begin
         if (sec_u_q == 4'd9) begin
            sec_u_d = 4'd0;
            sec_t_d = (sec_t_q == 4'd5) ? 4'd0 : sec_t_q + 4'd1;
         end else begin
            sec_u_d = sec_u_q + 4'd1;
         end
      end
      if (min_step) begin
         if (min_u_q == 4'd9) begin
            min_u_d = 4'd0;
            min_t_d = (min_t_q == 4'd5) ? 4'd0 : min_t_q + 4'd1;
         end else begin
            min_u_d = min_u_q + 4'd1;
         end
      end
      if (hr_step) begin
         if (hr_t_q == 4'd2 && hr_u_q == 4'd3) begin
            hr_u_d = 4'd0;
            hr_t_d = 4'd0;
         end else if (hr_u_q == 4'd9) begin
            hr_u_d = 4'd0;
            hr_t_d = hr_t_q + 4'd1;
         end else begin
            hr_u_d = hr_u_q + 4'd1;
         end
      end
   end

   always_comb begin
      scan_d = scan_q + SCAN_W'(1);
      idx_d  = idx_q;
      if (scan_q == SCAN_MAX) begin
         scan_d = '0;
         idx_d  = (idx_q == DIG_HT) ? DIG_SU : idx_q + 3'd1;
      end
   end

   always_comb begin
      case (idx_q)
         DIG_SU:  cur_digit = sec_u_q;
         DIG_ST:  cur_digit = sec_t_q;
         DIG_MU:  cur_digit = min_u_q;
         DIG_MT:  cur_digit = min_t_q;
         DIG_HU:  cur_digit = hr_u_q;
         DIG_HT:  cur_digit = hr_t_q;
         default: cur_digit = 4'hF;
      endcase
   end

   bcd_to_7seg u_dec (
      .bcd_i (cur_digit),
      .seg_o (seg)
   );

`ifdef COLON_BLINK_EN
   localparam logic [PRESC_W-1:0] PRESC_HALF = PRESC_W'(CLK_HZ / 2);
   assign dp_n = !(((idx_q == DIG_MU) || (idx_q == DIG_HU)) && (presc_q >= PRESC_HALF));
`else
   assign dp_n = 1'b1;
`endif

   assign uo_d  = {dp_n, seg[6:0]};
   assign uio_d = {2'b00, ~(6'b00_0001 << idx_q)};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         presc_q <= '0;
         sec_u_q <= 4'd0;
         sec_t_q <= 4'd0;
         min_u_q <= 4'd0;
         min_t_q <= 4'd0;
         hr_u_q  <= 4'd0;
         hr_t_q  <= 4'd0;
         scan_q  <= '0;
         idx_q   <= DIG_SU;
         uo_q    <= SEG_0;
         uio_q   <= 8'b0011_1110;
      end else begin
         sync1_q <= ui_in[4:0];
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         presc_q <= presc_d;
         sec_u_q <= sec_u_d;
         sec_t_q <= sec_t_d;
         min_u_q <= min_u_d;
         min_t_q <= min_t_d;
         hr_u_q  <= hr_u_d;
         hr_t_q  <= hr_t_d;
         scan_q  <= scan_d;
         idx_q   <= idx_d;
         uo_q    <= uo_d;
         uio_q   <= uio_d;
      end
   end

   assign uo_out  = uo_q;
   assign uio_out = uio_q;
   assign uio_oe  = 8'h3F;

endmodule

// File: tb/tb_digital_clock_top.sv
// Self-checking bench for digital_clock_top with CLK_HZ=10, SCAN_DIV=1 and a seconds-of-day model.
module tb_digital_clock_top;

   localparam int CLK_HZ   = 10;
   localparam int SCAN_DIV = 1;
   localparam int B_SET    = 0;
   localparam int B_INC_H  = 1;
   localparam int B_INC_M  = 2;
   localparam int B_CLR    = 3;
   localparam int B_HOLD   = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

   int tests_run    = 0;
   int tests_failed = 0;
   int tod     = 0;
   int presc_m = 0;
   logic [7:0] seg_s [6];
   logic [7:0] sel_s [6];

   always #10 clk = ~clk;

   digital_clock_top #(
      .CLK_HZ   (CLK_HZ),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   function automatic logic [7:0] seg_of(input int d);
      case (d)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic int slot_of(input logic [7:0] sel);
      int idx = -1;
      for (int i = 0; i < 6; i++) begin
         if (sel === (8'h3F & ~(8'h01 << i))) idx = i;
      end
      return idx;
   endfunction

   // Expected pattern for whichever slot the select lines point at; 00 for a bad select.
   function automatic logic [7:0] exp_seg(input logic [7:0] sel);
      int idx = slot_of(sel);
      int hh = tod / 3600;
      int mm = (tod / 60) % 60;
      int ss = tod % 60;
      int d;
      logic [7:0] r;
      case (idx)
         0: d = ss % 10;
         1: d = ss / 10;
         2: d = mm % 10;
         3: d = mm / 10;
         4: d = hh % 10;
         5: d = hh / 10;
         default: return 8'h00;
      endcase
      r = seg_of(d);
`ifdef COLON_BLINK_EN
      if ((idx == 2 || idx == 4) && presc_m >= CLK_HZ / 2) r[7] = 1'b0;
`endif
      return r;
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sample_scan();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seg_s[i] = uo_out;
         sel_s[i] = uio_out;
      end
   endtask

   task automatic pulse(input logic [7:0] mask, input int n);
      repeat (n) begin
         ui_in = ui_in | mask;
         wait_cyc(4);
         ui_in = ui_in & ~mask;
         wait_cyc(4);
      end
   endtask

   task automatic model_edit(input int dh, input int dm, input bit clr);
      int hh = tod / 3600;
      int mm = (tod / 60) % 60;
      int ss = tod % 60;
      if (clr) begin
         ss = 0;
         presc_m = 0;
      end
      mm = (mm + dm) % 60;
      hh = (hh + dh) % 24;
      tod = hh * 3600 + mm * 60 + ss;
   endtask

   // Hold is released for m cycles; the prescaler advances exactly m counts.
   task automatic run_free(input int m);
      ui_in[B_HOLD] = 1'b0;
      wait_cyc(m);
      ui_in[B_HOLD] = 1'b1;
      wait_cyc(4);
      presc_m = presc_m + m;
      tod = (tod + presc_m / CLK_HZ) % 86400;
      presc_m = presc_m % CLK_HZ;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ena = 1'b1;
      ui_in = 8'h00;
      uio_in = 8'h00;
      #100;
      tests_run++;
      if (uo_out !== 8'hC0) begin
         tests_failed++;
         $display("FAIL reset_uo_out: got %h, expected c0", uo_out);
      end
      tests_run++;
      if (uio_out !== 8'b0011_1110) begin
         tests_failed++;
         $display("FAIL reset_uio_out: got %h, expected 3e", uio_out);
      end
      @(negedge clk);
      rst = 1'b0;
      wait_cyc(5);
      ui_in = 8'd20;
      uio_in = 8'd30;
      @(negedge clk);
      tests_run++;
      if (uo_out !== 8'd192) begin
         tests_failed++;
         $display("FAIL post_reset_uo_out: got %h, expected c0", uo_out);
      end
      tests_run++;
      if (uio_oe !== 8'h3F) begin
         tests_failed++;
         $display("FAIL uio_oe: got %h, expected 3f", uio_oe);
      end
      tod = 0;
   endtask

   task automatic test_run_ticks();
      ui_in = 8'h11;
      wait_cyc(4);
      pulse(8'h01 << B_CLR, 1);
      model_edit(0, 0, 1'b1);
      ui_in[B_SET] = 1'b0;
      wait_cyc(4);
      run_free(10 * CLK_HZ);
      sample_scan();
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (seg_s[i] !== exp_seg(sel_s[i])) begin
            tests_failed++;
            $display("FAIL run_ticks sel=%h: got %h, expected %h", sel_s[i], seg_s[i],
                     exp_seg(sel_s[i]));
         end
      end
   endtask

   task automatic test_rollover();
      ui_in = 8'h11;
      wait_cyc(4);
      pulse(8'h01 << B_CLR, 1);
      pulse(8'h01 << B_INC_H, 23);
      pulse(8'h01 << B_INC_M, 59);
      model_edit(23, 59, 1'b1);
      ui_in[B_SET] = 1'b0;
      wait_cyc(4);
      run_free(59 * CLK_HZ + CLK_HZ / 2);
      sample_scan();
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (seg_s[i] !== exp_seg(sel_s[i])) begin
            tests_failed++;
            $display("FAIL preload_235959 sel=%h: got %h, expected %h", sel_s[i], seg_s[i],
                     exp_seg(sel_s[i]));
         end
      end
      run_free(CLK_HZ);
      sample_scan();
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (seg_s[i] !== exp_seg(sel_s[i])) begin
            tests_failed++;
            $display("FAIL rollover sel=%h: got %h, expected %h", sel_s[i], seg_s[i],
                     exp_seg(sel_s[i]));
         end
      end
   endtask

   // Prescaler runs freely here but set_mode must swallow every tick.
   task automatic test_set_minutes61();
      ui_in[B_SET] = 1'b1;
      wait_cyc(4);
      ui_in[B_HOLD] = 1'b0;
      pulse(8'h01 << B_INC_M, 61);
      ui_in[B_HOLD] = 1'b1;
      wait_cyc(4);
      presc_m = (presc_m + 61 * 8) % CLK_HZ;
      model_edit(0, 61, 1'b0);
      ui_in[B_SET] = 1'b0;
      wait_cyc(4);
      sample_scan();
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (seg_s[i] !== exp_seg(sel_s[i])) begin
            tests_failed++;
            $display("FAIL set_minutes61 sel=%h: got %h, expected %h", sel_s[i], seg_s[i],
                     exp_seg(sel_s[i]));
         end
      end
   endtask

   task automatic test_ignored_edits();
      ui_in = 8'h10;
      wait_cyc(4);
      pulse(8'h01 << B_INC_H, 3);
      pulse(8'h01 << B_INC_M, 3);
      pulse(8'h01 << B_CLR, 1);
      sample_scan();
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (seg_s[i] !== exp_seg(sel_s[i])) begin
            tests_failed++;
            $display("FAIL edits_without_set_mode sel=%h: got %h, expected %h", sel_s[i],
                     seg_s[i], exp_seg(sel_s[i]));
         end
      end
   endtask

   task automatic test_hold();
      logic [5:0] seen = '0;
      ui_in = 8'h10;
      wait_cyc(44);
      sample_scan();
      for (int i = 0; i < 6; i++) begin
         if (slot_of(sel_s[i]) >= 0) seen[slot_of(sel_s[i])] = 1'b1;
         tests_run++;
         if (seg_s[i] !== exp_seg(sel_s[i])) begin
            tests_failed++;
            $display("FAIL hold_time sel=%h: got %h, expected %h", sel_s[i], seg_s[i],
                     exp_seg(sel_s[i]));
         end
      end
      tests_run++;
      if (seen !== 6'h3F) begin
         tests_failed++;
         $display("FAIL hold_scan_selects: got mask %b, expected 111111", seen);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int nh = $urandom_range(0, 25);
         int nm = $urandom_range(0, 65);
         int nb = $urandom_range(0, 4);
         int cl = $urandom_range(0, 1);
         int m  = $urandom_range(0, 400);
         ui_in = 8'h11;
         wait_cyc(4);
         if (cl == 1) pulse(8'h01 << B_CLR, 1);
         pulse(8'h01 << B_INC_H, nh);
         pulse(8'h01 << B_INC_M, nm);
         pulse((8'h01 << B_INC_H) | (8'h01 << B_INC_M), nb);
         model_edit(nh + nb, nm + nb, cl == 1);
         ui_in[B_SET] = 1'b0;
         wait_cyc(4);
         run_free(m);
         sample_scan();
         for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (seg_s[i] !== exp_seg(sel_s[i])) begin
               tests_failed++;
               $display("FAIL random_%0d sel=%h: got %h, expected %h", it, sel_s[i], seg_s[i],
                        exp_seg(sel_s[i]));
            end
         end
      end
   endtask

   task automatic test_async_reset();
      ui_in = 8'h00;
      wait_cyc($urandom_range(20, 60));
      #3;
      rst = 1'b1;
      #1;
      tests_run++;
      if (uo_out !== 8'hC0 || uio_out !== 8'b0011_1110) begin
         tests_failed++;
         $display("FAIL async_reset: got uo=%h uio=%h, expected c0 3e", uo_out, uio_out);
      end
      ui_in = 8'h10;
      @(negedge clk);
      rst = 1'b0;
      tod = 0;
      presc_m = 2;
      wait_cyc(6);
      sample_scan();
      for (int i = 0; i < 6; i++) begin
         tests_run++;
         if (seg_s[i] !== exp_seg(sel_s[i])) begin
            tests_failed++;
            $display("FAIL after_async_reset sel=%h: got %h, expected %h", sel_s[i], seg_s[i],
                     exp_seg(sel_s[i]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_run_ticks();
      test_rollover();
      test_set_minutes61();
      test_ignored_edits();
      test_hold();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
